// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the scoreboarded register file: default
// parameter values, the immediate width and the init/ready state type.
package regfile_sb_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_ZERO_REG = 1;
    localparam int DEF_BYPASS   = 1;
    localparam int IMM_W        = 16;

    // ST_INIT sweeps every register to zero; ST_READY is normal operation.
    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_sb_imm_ext.sv
// Immediate extender: widens the 16-bit instruction immediate to the
// datapath width, either sign-extended or zero-extended.
module imm_ext
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              i_extOp,
    input  logic [IMM_W-1:0]  i_imm,
    output logic [DATA_W-1:0] o_extImm
);

    logic w_fill;

    // The fill bit is the immediate's sign bit only in sign-extend mode.
    assign w_fill   = i_extOp & i_imm[IMM_W-1];
    assign o_extImm = {{(DATA_W-IMM_W){w_fill}}, i_imm};

endmodule

// File: rtl/regfile_sb.sv
// Two-read / one-write register file with a busy-bit scoreboard,
// optional same-cycle write forwarding, an optional hardwired zero
// register and a post-reset sweep that clears every register.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = DEF_BYPASS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_add,
    input  logic [ADDR_W-1:0] rt_add,
    output logic [DATA_W-1:0] Rs_Data,
    output logic [DATA_W-1:0] Rt_Data,
    input  logic              regWrite,
    input  logic              regDst,
    input  logic [ADDR_W-1:0] rd_add,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] Rd_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_add,
    output logic              rs_busy,
    output logic              rt_busy,
    input  logic              extOp,
    input  logic [IMM_W-1:0]  imm_val_iType,
    output logic [DATA_W-1:0] ext_imm,
    output logic              init_done
);

    localparam int NREGS     = 1 << ADDR_W;
    localparam bit ZERO_EN   = (ZERO_REG != 0);
    localparam bit BYPASS_EN = (BYPASS != 0);

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_clrCnt;
    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  r_busy;
    logic [DATA_W-1:0] r_rdData;

    logic              w_inInit;
    logic              w_ready;
    logic              w_clrLast;
    logic [ADDR_W-1:0] w_wrTarget;
    logic              w_wrReq;
    logic              w_wrZeroDrop;
    logic              w_wrAccept;
    logic              w_issueAccept;
    logic              w_fwdRs;
    logic              w_fwdRt;
    logic [DATA_W-1:0] w_rsData;
    logic [DATA_W-1:0] w_rtData;

    // State register: reset always returns to the clearing sweep.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: leave INIT after the last register has been cleared; READY is terminal.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_INIT:  if (w_clrLast) w_nextState = ST_READY;
            ST_READY: w_nextState = ST_READY;
            default:  w_nextState = ST_INIT;
        endcase
    end

    // State decode used by the datapath and exported as init_done.
    always_comb begin
        w_inInit  = (r_state == ST_INIT);
        w_ready   = (r_state == ST_READY);
        init_done = w_ready;
    end

    assign w_clrLast = (r_clrCnt == ADDR_W'(NREGS - 1));

    // Sweep counter: walks every address once while in INIT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_clrCnt <= '0;
        end else if (w_inInit) begin
            r_clrCnt <= r_clrCnt + ADDR_W'(1);
        end
    end

    // A write to r0 is dropped when r0 is hardwired; the same holds for issues.
    assign w_wrTarget    = regDst ? rd_add : rt_add;
    assign w_wrReq       = w_ready & regWrite;
    assign w_wrZeroDrop  = ZERO_EN && (w_wrTarget == '0);
    assign w_wrAccept    = w_wrReq & ~w_wrZeroDrop;
    assign w_issueAccept = w_ready & issue_valid & ~(ZERO_EN && (issue_add == '0));

    // Storage array: cleared one entry per cycle in INIT, written by accepted writes in READY.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (w_inInit) begin
                r_regs[r_clrCnt] <= '0;
            end else if (w_wrAccept) begin
                r_regs[w_wrTarget] <= writeData;
            end
        end
    end

    // Last-stored-value register: a dropped r0 write stores (and reports) zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdData <= '0;
        end else if (w_wrReq) begin
            r_rdData <= w_wrZeroDrop ? '0 : writeData;
        end
    end

    assign Rd_data = r_rdData;

    // Scoreboard: a write retires its register, an issue marks one busy; the issue is applied last so it wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy <= '0;
        end else if (w_inInit) begin
            r_busy[r_clrCnt] <= 1'b0;
        end else begin
            if (w_wrAccept) begin
                r_busy[w_wrTarget] <= 1'b0;
            end
            if (w_issueAccept) begin
                r_busy[issue_add] <= 1'b1;
            end
        end
    end

    // Forwarding hits when this cycle's accepted write targets a read address.
    assign w_fwdRs = BYPASS_EN && w_wrAccept && (rs_add == w_wrTarget);
    assign w_fwdRt = BYPASS_EN && w_wrAccept && (rt_add == w_wrTarget);

    // Rs read port: zero during the sweep and for a hardwired r0, else forwarded or stored data.
    always_comb begin
        w_rsData = '0;
        if (w_ready && !(ZERO_EN && (rs_add == '0))) begin
            w_rsData = w_fwdRs ? writeData : r_regs[rs_add];
        end
    end

    // Rt read port: same selection rules as the Rs port.
    always_comb begin
        w_rtData = '0;
        if (w_ready && !(ZERO_EN && (rt_add == '0))) begin
            w_rtData = w_fwdRt ? writeData : r_regs[rt_add];
        end
    end

    assign Rs_Data = w_rsData;
    assign Rt_Data = w_rtData;

    // A forwarded operand is already available, so it never requests a stall.
    assign rs_busy = w_ready & r_busy[rs_add] & ~w_fwdRs;
    assign rt_busy = w_ready & r_busy[rt_add] & ~w_fwdRt;

    imm_ext #(
        .DATA_W (DATA_W)
    ) u_immExt (
        .i_extOp  (extOp),
        .i_imm    (imm_val_iType),
        .o_extImm (ext_imm)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset sweep timing, table-driven
// read/write/scoreboard/extension vectors, forwarding against a
// non-forwarding instance, and resets in READY and mid-sweep.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_add, rt_add, rd_add, issue_add;
    logic        regWrite, regDst, issue_valid, extOp;
    logic [31:0] writeData;
    logic [15:0] imm_val_iType;

    logic [31:0] Rs_Data, Rt_Data, Rd_data, ext_imm;
    logic        rs_busy, rt_busy, init_done;

    logic [31:0] nbRs, nbRt, nbRd, nbExt;
    logic        nbRsBusy, nbRtBusy, nbInitDone;

    int testsRun  = 0;
    int failCount = 0;
    int cycles;

    typedef struct {
        logic        we;
        logic        dst;
        logic [4:0]  rd;
        logic [4:0]  rt;
        logic [4:0]  rs;
        logic [31:0] wd;
        logic        iv;
        logic [4:0]  ia;
        logic        ext;
        logic [15:0] imm;
        logic [31:0] eRs;
        logic [31:0] eRt;
        logic        eRsB;
        logic        eRtB;
        logic [31:0] eExt;
        logic [31:0] eRd;
    } vec_t;

    vec_t vecs [16];

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk           (clk),
        .rst           (rst),
        .rs_add        (rs_add),
        .rt_add        (rt_add),
        .Rs_Data       (Rs_Data),
        .Rt_Data       (Rt_Data),
        .regWrite      (regWrite),
        .regDst        (regDst),
        .rd_add        (rd_add),
        .writeData     (writeData),
        .Rd_data       (Rd_data),
        .issue_valid   (issue_valid),
        .issue_add     (issue_add),
        .rs_busy       (rs_busy),
        .rt_busy       (rt_busy),
        .extOp         (extOp),
        .imm_val_iType (imm_val_iType),
        .ext_imm       (ext_imm),
        .init_done     (init_done)
    );

    regfile_sb #(.BYPASS(0)) dutNoBypass (
        .clk           (clk),
        .rst           (rst),
        .rs_add        (rs_add),
        .rt_add        (rt_add),
        .Rs_Data       (nbRs),
        .Rt_Data       (nbRt),
        .regWrite      (regWrite),
        .regDst        (regDst),
        .rd_add        (rd_add),
        .writeData     (writeData),
        .Rd_data       (nbRd),
        .issue_valid   (issue_valid),
        .issue_add     (issue_add),
        .rs_busy       (nbRsBusy),
        .rt_busy       (nbRtBusy),
        .extOp         (extOp),
        .imm_val_iType (imm_val_iType),
        .ext_imm       (nbExt),
        .init_done     (nbInitDone)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        regWrite      = v.we;
        regDst        = v.dst;
        rd_add        = v.rd;
        rt_add        = v.rt;
        rs_add        = v.rs;
        writeData     = v.wd;
        issue_valid   = v.iv;
        issue_add     = v.ia;
        extOp         = v.ext;
        imm_val_iType = v.imm;
    endtask

    task automatic idleInputs();
        regWrite    = 1'b0;
        issue_valid = 1'b0;
    endtask

    // Count edges until init_done rises; bounded so a stuck sweep still ends.
    task automatic waitInit(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!init_done && n < 100);
        idleInputs();
    endtask

    task automatic checkAllZero(input string tag);
        for (int i = 0; i < 32; i++) begin
            rs_add = 5'(i);
            rt_add = 5'(31 - i);
            #1;
            checkOutput($sformatf("%s rs r%0d", tag, i), Rs_Data, 32'h0);
            checkOutput($sformatf("%s rt r%0d", tag, 31 - i), Rt_Data, 32'h0);
            checkOutput($sformatf("%s busy r%0d", tag, i), {31'h0, rs_busy}, 32'h0);
        end
    endtask

    initial begin
        //            we    dst   rd     rt     rs     wd            iv    ia     ext   imm       eRs           eRt           eRsB  eRtB  eExt          eRd
        vecs[0]  = '{1'b1, 1'b1, 5'd5,  5'd0,  5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  1'b1, 16'h8001, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 32'hFFFF8001, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 1'b1, 5'd0,  5'd0,  5'd5,  32'h0,        1'b0, 5'd0,  1'b0, 16'h8001, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 32'h00008001, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b1, 5'd0,  5'd5,  5'd0,  32'hCAFEF00D, 1'b0, 5'd0,  1'b1, 16'h7FFF, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 32'h00007FFF, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 5'd0,  5'd5,  5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 16'h0000, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[4]  = '{1'b1, 1'b0, 5'd5,  5'd12, 5'd5,  32'h00001111, 1'b0, 5'd0,  1'b0, 16'hFFFF, 32'hDEADBEEF, 32'h00001111, 1'b0, 1'b0, 32'h0000FFFF, 32'h00001111};
        vecs[5]  = '{1'b1, 1'b1, 5'd7,  5'd12, 5'd7,  32'h00001234, 1'b0, 5'd0,  1'b1, 16'hFFFF, 32'h00001234, 32'h00001111, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00001234};
        vecs[6]  = '{1'b0, 1'b1, 5'd0,  5'd7,  5'd9,  32'h0,        1'b1, 5'd9,  1'b1, 16'hA5A5, 32'h0,        32'h00001234, 1'b0, 1'b0, 32'hFFFFA5A5, 32'h00001234};
        vecs[7]  = '{1'b0, 1'b1, 5'd0,  5'd9,  5'd9,  32'h0,        1'b0, 5'd0,  1'b1, 16'hA5A5, 32'h0,        32'h0,        1'b1, 1'b1, 32'hFFFFA5A5, 32'h00001234};
        vecs[8]  = '{1'b1, 1'b1, 5'd9,  5'd7,  5'd9,  32'hAAAA5555, 1'b0, 5'd0,  1'b1, 16'hA5A5, 32'hAAAA5555, 32'h00001234, 1'b0, 1'b0, 32'hFFFFA5A5, 32'hAAAA5555};
        vecs[9]  = '{1'b0, 1'b1, 5'd0,  5'd7,  5'd9,  32'h0,        1'b0, 5'd0,  1'b1, 16'hA5A5, 32'hAAAA5555, 32'h00001234, 1'b0, 1'b0, 32'hFFFFA5A5, 32'hAAAA5555};
        vecs[10] = '{1'b1, 1'b1, 5'd9,  5'd9,  5'd9,  32'h0BADF00D, 1'b1, 5'd9,  1'b1, 16'hA5A5, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 1'b0, 32'hFFFFA5A5, 32'h0BADF00D};
        vecs[11] = '{1'b0, 1'b1, 5'd0,  5'd9,  5'd9,  32'h0,        1'b0, 5'd0,  1'b1, 16'hA5A5, 32'h0BADF00D, 32'h0BADF00D, 1'b1, 1'b1, 32'hFFFFA5A5, 32'h0BADF00D};
        vecs[12] = '{1'b0, 1'b1, 5'd0,  5'd9,  5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 16'hA5A5, 32'h0,        32'h0BADF00D, 1'b0, 1'b1, 32'hFFFFA5A5, 32'h0BADF00D};
        vecs[13] = '{1'b0, 1'b1, 5'd0,  5'd9,  5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 16'hA5A5, 32'h0,        32'h0BADF00D, 1'b0, 1'b1, 32'hFFFFA5A5, 32'h0BADF00D};
        vecs[14] = '{1'b1, 1'b0, 5'd0,  5'd9,  5'd12, 32'h00000055, 1'b0, 5'd0,  1'b1, 16'hA5A5, 32'h00001111, 32'h00000055, 1'b0, 1'b0, 32'hFFFFA5A5, 32'h00000055};
        vecs[15] = '{1'b0, 1'b1, 5'd0,  5'd9,  5'd9,  32'h0,        1'b0, 5'd0,  1'b1, 16'hA5A5, 32'h00000055, 32'h00000055, 1'b0, 1'b0, 32'hFFFFA5A5, 32'h00000055};

        // Power-up reset held for two edges.
        rst = 1'b0;
        rs_add = 5'd0; rt_add = 5'd0; rd_add = 5'd0; issue_add = 5'd0;
        regWrite = 1'b0; regDst = 1'b0; issue_valid = 1'b0; extOp = 1'b0;
        writeData = 32'h0; imm_val_iType = 16'h0;
        tick();
        tick();
        checkOutput("reset init_done", {31'h0, init_done}, 32'h0);
        checkOutput("reset Rd_data", Rd_data, 32'h0);

        // Sweep with writes and issues attempted; all must be ignored.
        rst = 1'b1;
        regWrite = 1'b1; regDst = 1'b1; rd_add = 5'd3; writeData = 32'hFFFFFFFF;
        issue_valid = 1'b1; issue_add = 5'd3; rs_add = 5'd3; rt_add = 5'd3;
        #1;
        checkOutput("init rs_data", Rs_Data, 32'h0);
        checkOutput("init rs_busy", {31'h0, rs_busy}, 32'h0);
        waitInit(cycles);
        checkOutput("init latency", 32'(cycles), 32'd32);
        checkOutput("init Rd_data", Rd_data, 32'h0);
        checkAllZero("post-init");

        // Table-driven vectors: combinational outputs before the edge, Rd_data after it.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d rs_data", i), Rs_Data, vecs[i].eRs);
            checkOutput($sformatf("v%0d rt_data", i), Rt_Data, vecs[i].eRt);
            checkOutput($sformatf("v%0d rs_busy", i), {31'h0, rs_busy}, {31'h0, vecs[i].eRsB});
            checkOutput($sformatf("v%0d rt_busy", i), {31'h0, rt_busy}, {31'h0, vecs[i].eRtB});
            checkOutput($sformatf("v%0d ext_imm", i), ext_imm, vecs[i].eExt);
            tick();
            checkOutput($sformatf("v%0d Rd_data", i), Rd_data, vecs[i].eRd);
        end
        idleInputs();

        // Forwarding versus the non-forwarding instance.
        regWrite = 1'b1; regDst = 1'b1; rd_add = 5'd7; writeData = 32'h00005678;
        rs_add = 5'd7; rt_add = 5'd9; extOp = 1'b0; imm_val_iType = 16'h8001;
        #1;
        checkOutput("bypass rs", Rs_Data, 32'h00005678);
        checkOutput("nobypass rs", nbRs, 32'h00001234);
        checkOutput("nobypass rt", nbRt, 32'h00000055);
        checkOutput("nobypass ext", nbExt, 32'h00008001);
        tick();
        regWrite = 1'b0;
        #1;
        checkOutput("nobypass Rd_data", nbRd, 32'h00005678);
        checkOutput("nobypass rs after", nbRs, 32'h00005678);

        // Busy forwarding: the non-forwarding instance must still stall.
        issue_valid = 1'b1; issue_add = 5'd9;
        tick();
        issue_valid = 1'b0;
        regWrite = 1'b1; rd_add = 5'd9; writeData = 32'h00000099; rs_add = 5'd9; rt_add = 5'd9;
        #1;
        checkOutput("bypass busy rs", {31'h0, rs_busy}, 32'h0);
        checkOutput("nobypass busy rs", {31'h0, nbRsBusy}, 32'h1);
        checkOutput("nobypass busy rt", {31'h0, nbRtBusy}, 32'h1);
        checkOutput("nobypass old rs", nbRs, 32'h00000055);
        tick();
        checkOutput("busy-clear Rd_data", Rd_data, 32'h00000099);
        regWrite = 1'b0;
        issue_valid = 1'b1; issue_add = 5'd22;
        tick();
        issue_valid = 1'b0;
        rs_add = 5'd22;
        #1;
        checkOutput("issue r22 busy", {31'h0, rs_busy}, 32'h1);

        // Reset from READY in the middle of a write.
        regWrite = 1'b1; rd_add = 5'd5; writeData = 32'h12345678;
        rst = 1'b0;
        tick();
        rs_add = 5'd5;
        #1;
        checkOutput("midrst init_done", {31'h0, init_done}, 32'h0);
        checkOutput("midrst nb init_done", {31'h0, nbInitDone}, 32'h0);
        checkOutput("midrst Rd_data", Rd_data, 32'h0);
        checkOutput("midrst rs_data", Rs_Data, 32'h0);
        tick();
        rst = 1'b1;
        waitInit(cycles);
        checkOutput("midrst latency", 32'(cycles), 32'd32);
        checkAllZero("midrst");

        // Reset during the sweep restarts it from address 0.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        waitInit(cycles);
        checkOutput("initrst latency", 32'(cycles), 32'd32);
        checkOutput("initrst init_done", {31'h0, init_done}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register and data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning address width; register count NREGS = 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 1, meaning register 0 reads 0 and ignores writes when 1.
REQ-004 SHALL have parameter BYPASS, default 1, meaning same-cycle write-to-read forwarding is enabled when 1.
REQ-005 SHALL have one clock; reset is synchronous and active-low. Ports are clk and rst.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-low reset.
REQ-008 rs_add, rt_add  input  ADDR_W  read port addresses.
REQ-009 Rs_Data, Rt_Data  output  DATA_W  read port data, combinational.
REQ-010 regWrite  input  1  write request.
REQ-011 regDst  input  1  write target select: 1 selects rd_add, 0 selects rt_add.
REQ-012 rd_add  input  ADDR_W  destination address for R-type writes.
REQ-013 writeData  input  DATA_W  write data.
REQ-014 Rd_data  output  DATA_W  registered copy of the last value actually stored.
REQ-015 issue_valid  input  1  marks issue_add as having a pending producer.
REQ-016 issue_add  input  ADDR_W  register to mark busy.
REQ-017 rs_busy, rt_busy  output  1  read operand not yet valid (stall request).
REQ-018 extOp, imm_val_iType  input  1, 16  extension mode (1 = sign, 0 = zero) and immediate.
REQ-019 ext_imm  output  DATA_W  extended immediate, combinational.
REQ-020 init_done  output  1  high once register clearing is complete.

Function
REQ-021 SHALL implement a two-state FSM, INIT and READY; reset forces INIT with clear counter 0.
REQ-022 In INIT, each cycle SHALL write 0 to register[counter], clear busy[counter], and increment the counter; at counter NREGS-1 the FSM SHALL move to READY on the next edge (NREGS cycles total).
REQ-023 In INIT, regWrite and issue_valid SHALL be ignored, Rs_Data/Rt_Data SHALL read 0, rs_busy/rt_busy SHALL be 0, and init_done SHALL be 0.
REQ-024 In READY, init_done SHALL be 1; the FSM SHALL leave READY only on reset.
REQ-025 Write target T = regDst ? rd_add : rt_add; when regWrite is high in READY, register[T] SHALL take writeData at the clock edge.
REQ-026 If ZERO_REG=1 and T=0, the write SHALL be discarded, Rd_data SHALL load 0, and reads of address 0 SHALL always return 0.
REQ-027 Rd_data SHALL load the stored value on every accepted write and hold it otherwise.
REQ-028 If BYPASS=1, regWrite is high in READY, and a read address equals T (with T nonzero when ZERO_REG=1), that read port SHALL return writeData in the same cycle; if BYPASS=0 it SHALL return the old value.
REQ-029 issue_valid in READY SHALL set busy[issue_add] at the edge; an issue to address 0 SHALL be ignored when ZERO_REG=1.
REQ-030 An accepted write SHALL clear busy[T]; if the same edge also sets busy[T] via issue, the set SHALL win.
REQ-031 rs_busy SHALL equal busy[rs_add] AND NOT (BYPASS and a write to rs_add this cycle); rt_busy SHALL follow the same rule for rt_add.
REQ-032 ext_imm SHALL be the immediate sign-extended to DATA_W when extOp=1, and zero-extended otherwise; it is independent of the FSM state.

Reset
REQ-033 rst low at any edge, including mid-INIT or mid-write, SHALL force INIT, counter 0, Rd_data 0, and all busy bits 0.
REQ-034 Register contents SHALL be defined only by the INIT sweep and SHALL be 0 when init_done first rises.

Structure
REQ-035 Package regfile_sb_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-036 Immediate extension SHALL be a sub-module named imm_ext, parametrised by DATA_W.

Verification
REQ-037 Reset: hold rst low 2 cycles, then release -> init_done rises exactly 32 cycles later (defaults), and all 32 registers read 0.
REQ-038 Write/read: write 0xDEADBEEF to r5 with regDst=1 -> next cycle Rs_Data=0xDEADBEEF and Rd_data=0xDEADBEEF; a write to r0 -> r0 still reads 0 and Rd_data=0.
REQ-039 Bypass: in one cycle regWrite to r7 with 0x1234 and rs_add=7 -> Rs_Data=0x1234 that same cycle; with BYPASS=0, Rs_Data shows the old value.
REQ-040 Scoreboard: issue r9 -> rs_busy=1 when rs_add=9; write r9 -> busy cleared; issue and write r9 in the same cycle -> rs_busy stays 1 afterwards.
REQ-041 Extension: imm 0x8001 with extOp=1 -> ext_imm=0xFFFF8001; with extOp=0 -> 0x00008001.
REQ-042 Mid-operation reset: assert rst during READY after writes -> init_done=0, busy bits cleared, and after the sweep all registers read 0.
